// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 4-source round-robin mux arbiter.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {IDLE, GRANT} arb_state_t;
    typedef logic [SEL_W-1:0] sel_t;

    function automatic logic [NUM_REQ-1:0] onehot(input sel_t idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first eligible request after `last`.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  sel_t               last,
    output sel_t               idx,
    output logic               found
);

    logic [NUM_REQ-1:0] eligible;
    sel_t               cand;

    // Scan last+1, last+2, ... wrapping; sel_t arithmetic provides the mod-4 wrap.
    always_comb begin
        eligible = req & ~mask;
        idx      = '0;
        found    = 1'b0;
        cand     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = last + sel_t'(i);
            if (!found && eligible[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin arbiter driving the select lines of mux_4_1.
// Optional grant-tenure timeout with preemption: define MUX_ARB_TIMEOUT_EN.
module mux_4_1_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               sel0,
    output logic               sel1,
    output logic               valid,
    output logic               preempt
);

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_range
        $error("HOLD_MAX must be within 2..255");
    end

    arb_state_t         state_q, state_d;
    sel_t               owner_q, owner_d;
    sel_t               last_q, last_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               valid_q, valid_d;
    logic               preempt_q, preempt_d;

    logic [NUM_REQ-1:0] pick_mask;
    sel_t               pick_last;
    sel_t               pick_idx;
    logic               pick_found;
    logic               in_grant;
    logic               owner_req;
    logic               timeout;
    logic               rotate;
    logic               new_grant;

    assign in_grant  = (state_q == GRANT);
    assign owner_req = req[owner_q];
    // While granted, the owner is excluded and the scan starts just after it.
    assign pick_mask = in_grant ? onehot(owner_q) : '0;
    assign pick_last = in_grant ? owner_q : last_q;

    rr_pick4 u_pick (
        .req   (req),
        .mask  (pick_mask),
        .last  (pick_last),
        .idx   (pick_idx),
        .found (pick_found)
    );

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int               CNT_W   = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] cnt_q;

    // Only preempt when someone else is actually waiting.
    assign timeout = in_grant && owner_req && (cnt_q == CNT_MAX) && pick_found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (new_grant) begin
            cnt_q <= '0;
        end else if (in_grant && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        valid_d   = valid_q;
        preempt_d = 1'b0;
        new_grant = 1'b0;
        rotate    = in_grant && (!owner_req || timeout);

        if (rotate) begin
            last_d = owner_q;
        end

        if ((!in_grant || rotate) && pick_found) begin
            state_d   = GRANT;
            owner_d   = pick_idx;
            gnt_d     = onehot(pick_idx);
            valid_d   = 1'b1;
            preempt_d = timeout;
            new_grant = 1'b1;
        end else if (rotate) begin
            // Select lines deliberately keep the last owner's index while idle.
            state_d = IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            last_q    <= sel_t'(NUM_REQ - 1);
            gnt_q     <= '0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            valid_q   <= valid_d;
            preempt_q <= preempt_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel0    = owner_q[0];
    assign sel1    = owner_q[1];
    assign valid   = valid_q;
    assign preempt = preempt_q;

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Scoreboard bench for mux_4_1_rr_arbiter; model follows the arbitration rules directly.
module tb_mux_4_1_rr_arbiter;

    localparam int HOLD = 4;
`ifdef MUX_ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic       sel0, sel1, valid, preempt;

    typedef struct {
        int         cyc;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic       preempt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Reference model state: owner -1 means nobody granted.
    int         m_owner = -1;
    int         m_last = 3;
    int         m_ten = 0;
    logic [1:0] m_sel = 2'b00;

    mux_4_1_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .sel0    (sel0),
        .sel1    (sel1),
        .valid   (valid),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            mon_e = q.pop_front();
            check("stale_expectation", mon_e.cyc, cyc);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            mon_e = q.pop_front();
            check("gnt_sel_valid_preempt", {23'd0, gnt, sel1, sel0, valid, preempt},
                  {23'd0, mon_e.gnt, mon_e.sel, mon_e.valid, mon_e.preempt});
        end
    end

    function automatic int pick(input logic [3:0] r, input int from, input int excl);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (from + k) % 4;
            if (r[c] && c != excl) return c;
        end
        return -1;
    endfunction

    // Called one time unit after a rising edge; applies r and predicts the next edge.
    task automatic step(input logic [3:0] r);
        exp_t e;
        int   nxt;
        logic pre;
        pre = 1'b0;
        req = r;
        if (m_owner < 0) begin
            nxt = pick(r, m_last, -1);
            if (nxt >= 0) begin
                m_owner = nxt;
                m_ten   = 1;
            end
        end else if (!r[m_owner]) begin
            m_last  = m_owner;
            m_owner = pick(r, m_owner, m_owner);
            m_ten   = 1;
        end else if (TMO && m_ten >= HOLD && pick(r, m_owner, m_owner) >= 0) begin
            m_last  = m_owner;
            m_owner = pick(r, m_owner, m_owner);
            m_ten   = 1;
            pre     = 1'b1;
        end else begin
            m_ten++;
        end
        if (m_owner >= 0) m_sel = m_owner[1:0];
        e.cyc     = cyc + 1;
        e.gnt     = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        e.sel     = m_sel;
        e.valid   = (m_owner >= 0);
        e.preempt = pre;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("async_reset_clear", {28'd0, gnt, sel1, sel0, valid, preempt}, 32'd0);
        m_owner = -1;
        m_last  = 3;
        m_ten   = 0;
        m_sel   = 2'b00;
        repeat (2) @(posedge clk);
        #1 check("reset_hold", {28'd0, gnt, sel1, sel0, valid, preempt}, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] r;

        // Reset with everyone requesting; source 0 must win first.
        req = 4'b1111;
        #2 rst_n = 1'b0;
        #1 check("power_on_reset", {28'd0, gnt, sel1, sel0, valid, preempt}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step(4'b1111);
        step(4'b1111);

        // Rotation through all owners by dropping the current owner's bit.
        repeat (5) begin
            step(4'b1111 & ~(4'b0001 << m_owner));
            step(4'b1111);
        end

        // Lone requester then release to idle; select lines must hold.
        repeat (3) step(4'b0100);
        repeat (3) step(4'b0000);

        // Asynchronous reset in the middle of a grant to source 3.
        repeat (2) step(4'b1000);
        apply_reset();
        repeat (2) step(4'b1000);

        // Tenure limit: two competitors, then a lone requester.
        apply_reset();
        repeat (12) step(4'b0011);
        repeat (10) step(4'b0001);
        repeat (2) step(4'b0000);

        // Randomised traffic with sticky requests so tenures get long.
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            if (m_owner >= 0 && $urandom_range(0, 7) == 0) r[m_owner] = 1'b0;
            step(r);
        end
        repeat (2) step(4'b0000);

        repeat (2) @(negedge clk);
        #1 check("scoreboard_drained", q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
